shuffling_card_dealer: RTL and testbench

//  Parametrised blackjack card source. Holds NUM_DECKS x 52 card values (1..10, face cards = 10).

---
 rtl/shuffling_card_dealer.sv | 154 +++++++++++++++
 tb/tb_shuffling_card_dealer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shuffling_card_dealer.sv
// Blackjack shoe: loads NUM_DECKS x 52 card values, optionally Fisher-Yates shuffles them
// in place using a free-running Galois LFSR, then deals one card per request.
module shuffling_card_dealer #(
    parameter int                NUM_DECKS  = 1,
    parameter bit                SHUFFLE_EN = 1'b1,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1),
    localparam int               DECK_SIZE  = 52 * NUM_DECKS,
    localparam int               CNT_W      = $clog2(DECK_SIZE + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             deal_req_i,
    input  logic             shuffle_req_i,
    output logic [4:0]       card_o,
    output logic             card_valid_o,
    output logic             busy_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] cards_left_o
);

    localparam int IDX_W = $clog2(DECK_SIZE);
    // Right-shift Galois feedback masks for maximal-length 16/24/32-bit polynomials.
    localparam logic [31:0]       TAPS_ALL = (LFSR_W == 24) ? 32'h00E1_0000 :
                                             (LFSR_W == 32) ? 32'h8020_0003 : 32'h0000_B400;
    localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

    typedef enum logic [1:0] {ST_LOAD, ST_SHUFFLE, ST_READY} state_t;

    state_t            state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  left_q;
    logic [4:0]        card_q;
    logic              valid_q;
    logic              busy_q;
    logic              empty_q;

    logic [3:0]        deck_q   [DECK_SIZE];
    logic [3:0]        init_val [DECK_SIZE];
    logic [IDX_W-1:0]  mask;
    logic [IDX_W-1:0]  r_idx;
    logic [3:0]        deck_i;
    logic [3:0]        deck_r;
    logic              load;
    logic              accept;
    logic              deal_fire;

    for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_init
        assign init_val[gi] = ((gi % 13) >= 9) ? 4'd10 : 4'((gi % 13) + 1);
    end

    assign lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

    // Smallest all-ones mask covering i: ones up to and including the MSB set in i.
    always_comb begin
        mask = '0;
        for (int b = 0; b < IDX_W; b++) begin
            if ((i_q >> b) != '0) begin
                mask[b] = 1'b1;
            end
        end
    end

    assign r_idx     = lfsr_q[IDX_W-1:0] & mask;
    assign deck_i    = deck_q[i_q];
    assign deck_r    = deck_q[r_idx];
    assign load      = (state_q == ST_LOAD);
    assign accept    = (state_q == ST_SHUFFLE) && (r_idx <= i_q) && !shuffle_req_i;
    assign deal_fire = (state_q == ST_READY) && deal_req_i && (left_q != '0) && !shuffle_req_i;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DECK_SIZE; k++) begin
            if (load) begin
                deck_q[k] <= init_val[k];
            end else if (accept && (i_q == IDX_W'(k))) begin
                deck_q[k] <= deck_r;
            end else if (accept && (r_idx == IDX_W'(k))) begin
                deck_q[k] <= deck_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_LOAD;
            lfsr_q  <= SEED;
            i_q     <= '0;
            ptr_q   <= '0;
            left_q  <= '0;
            card_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            empty_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            valid_q <= 1'b0;
            if (shuffle_req_i) begin
                state_q <= ST_LOAD;
                busy_q  <= 1'b1;
                empty_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        i_q     <= IDX_W'(DECK_SIZE - 1);
                        ptr_q   <= '0;
                        left_q  <= CNT_W'(DECK_SIZE);
                        empty_q <= 1'b0;
                        if (SHUFFLE_EN) begin
                            state_q <= ST_SHUFFLE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READY;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_SHUFFLE: begin
                        if (accept) begin
                            i_q <= i_q - IDX_W'(1);
                            if (i_q == IDX_W'(1)) begin
                                state_q <= ST_READY;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ST_READY: begin
                        if (deal_fire) begin
                            card_q  <= {1'b0, deck_q[ptr_q]};
                            valid_q <= 1'b1;
                            ptr_q   <= ptr_q + IDX_W'(1);
                            left_q  <= left_q - CNT_W'(1);
                            if (left_q == CNT_W'(1)) begin
                                empty_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign card_o       = card_q;
    assign card_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign empty_o      = empty_q;
    assign cards_left_o = left_q;

endmodule

// File: tb/tb_shuffling_card_dealer.sv
// Bench for shuffling_card_dealer: a canonical-order 1-deck shoe and a shuffled 2-deck shoe,
// cards checked through scoreboards fed from a table and from a reference Fisher-Yates model.
module tb_shuffling_card_dealer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       c_rst_n, c_deal, c_shuf, c_valid, c_busy, c_empty;
    logic [4:0] c_card;
    logic [5:0] c_left;
    logic       s_rst_n, s_deal, s_shuf, s_valid, s_busy, s_empty;
    logic [4:0] s_card;
    logic [6:0] s_left;

    shuffling_card_dealer #(.NUM_DECKS(1), .SHUFFLE_EN(1'b0)) u_canon (
        .clk_i(clk), .rst_ni(c_rst_n), .deal_req_i(c_deal), .shuffle_req_i(c_shuf),
        .card_o(c_card), .card_valid_o(c_valid), .busy_o(c_busy), .empty_o(c_empty),
        .cards_left_o(c_left)
    );

    shuffling_card_dealer #(.NUM_DECKS(2), .SHUFFLE_EN(1'b1)) u_shuf (
        .clk_i(clk), .rst_ni(s_rst_n), .deal_req_i(s_deal), .shuffle_req_i(s_shuf),
        .card_o(s_card), .card_valid_o(s_valid), .busy_o(s_busy), .empty_o(s_empty),
        .cards_left_o(s_left)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboards: expected cards pushed when a request is driven, popped when a strobe appears.
    int c_exp_q[$];
    int s_exp_q[$];
    int c_dealt[$];
    int s_dealt[$];
    int c_valid_cnt = 0;
    int s_valid_cnt = 0;
    bit s_free = 1'b0;

    always @(negedge clk) begin
        if (c_valid) begin
            c_valid_cnt++;
            c_dealt.push_back(int'(c_card));
            if (c_exp_q.size() == 0) check("c_card_unexpected", 1, 0);
            else check("c_card", int'(c_card), c_exp_q.pop_front());
        end
        if (s_valid) begin
            s_valid_cnt++;
            s_dealt.push_back(int'(s_card));
            if (!s_free) begin
                if (s_exp_q.size() == 0) check("s_card_unexpected", 1, 0);
                else check("s_card", int'(s_card), s_exp_q.pop_front());
            end
        end
    end

    function automatic int canon(input int k);
        int v;
        v = (k % 13) + 1;
        return (v > 10) ? 10 : v;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference shuffle of the 2-deck shoe, reproducing the LFSR phase seen after reset.
    int model_deck[104];
    int model_cycles;
    int run1[104];

    task automatic build_model();
        logic [15:0] l;
        int i, m, r, t;
        for (int k = 0; k < 104; k++) model_deck[k] = canon(k);
        l = lfsr_step(16'hACE1);
        i = 103;
        model_cycles = 0;
        while (i > 0) begin
            model_cycles++;
            m = 1;
            while (m < i) m = m * 2 + 1;
            r = int'(l) & m;
            if (r <= i) begin
                t = model_deck[i];
                model_deck[i] = model_deck[r];
                model_deck[r] = t;
                i--;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic wait_ready_c(output int cyc);
        cyc = 0;
        while (c_busy && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (c_busy) check("c_ready_timeout", 1, 0);
    endtask

    task automatic wait_ready_s(output int cyc);
        cyc = 0;
        while (s_busy && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (s_busy) check("s_ready_timeout", 1, 0);
    endtask

    task automatic run_shuffle(input int run);
        int cyc, diff, mm;
        int h[11];
        s_dealt.delete();
        s_free = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1;
        wait_ready_s(cyc);
        check("s_busy_cycles", cyc, model_cycles + 1);
        check("s_left_full", int'(s_left), 104);
        check("s_empty_full", int'(s_empty), 0);
        for (int k = 0; k < 104; k++) begin
            s_deal = 1'b1;
            s_exp_q.push_back(model_deck[k]);
            @(negedge clk);
        end
        s_deal = 1'b0;
        @(negedge clk);
        check("s_sb_drained", s_exp_q.size(), 0);
        check("s_dealt_count", s_dealt.size(), 104);
        check("s_left_zero", int'(s_left), 0);
        check("s_empty_set", int'(s_empty), 1);
        for (int v = 0; v < 11; v++) h[v] = 0;
        diff = 0;
        mm = 0;
        for (int k = 0; k < s_dealt.size(); k++) begin
            if (s_dealt[k] >= 1 && s_dealt[k] <= 10) h[s_dealt[k]]++;
            if (k < 104 && s_dealt[k] != canon(k)) diff++;
        end
        for (int v = 1; v <= 9; v++) check($sformatf("s_hist_%0d", v), h[v], 8);
        check("s_hist_10", h[10], 32);
        check("s_order_shuffled", int'(diff > 0), 1);
        for (int k = 0; k < 104; k++) begin
            if (run == 0) run1[k] = (k < s_dealt.size()) ? s_dealt[k] : -1;
            else if (k >= s_dealt.size() || s_dealt[k] != run1[k]) mm++;
        end
        if (run != 0) check("s_repeatable", mm, 0);
    endtask

    typedef struct {
        bit deal;
        bit shuf;
        bit exp_valid;
        int exp_card;
        bit exp_busy;
        bit exp_empty;
        int exp_left;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int cyc, v0, strobes;
        int h[11];
        for (int k = 0; k < 13; k++) vecs[k] = '{1'b1, 1'b0, 1'b1, canon(k), 1'b0, 1'b0, 51 - k};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 39};

        c_rst_n = 1'b0; c_deal = 1'b0; c_shuf = 1'b0;
        s_rst_n = 1'b0; s_deal = 1'b0; s_shuf = 1'b0;
        repeat (3) @(negedge clk);
        check("c_rst_card", int'(c_card), 0);
        check("c_rst_valid", int'(c_valid), 0);
        check("c_rst_busy", int'(c_busy), 1);
        check("c_rst_empty", int'(c_empty), 0);
        check("c_rst_left", int'(c_left), 0);
        check("s_rst_card", int'(s_card), 0);
        check("s_rst_valid", int'(s_valid), 0);
        check("s_rst_busy", int'(s_busy), 1);
        check("s_rst_empty", int'(s_empty), 0);
        check("s_rst_left", int'(s_left), 0);
        build_model();

        // Canonical order, table-driven, one card per cycle.
        c_rst_n = 1'b1;
        wait_ready_c(cyc);
        check("c_load_cycles", cyc, 1);
        check("c_left_full", int'(c_left), 52);
        for (int i = 0; i <= 14; i++) begin
            if (i > 0) begin
                check($sformatf("t1_valid_%0d", i - 1), int'(c_valid), int'(vecs[i-1].exp_valid));
                check($sformatf("t1_busy_%0d", i - 1), int'(c_busy), int'(vecs[i-1].exp_busy));
                check($sformatf("t1_empty_%0d", i - 1), int'(c_empty), int'(vecs[i-1].exp_empty));
                check($sformatf("t1_left_%0d", i - 1), int'(c_left), vecs[i-1].exp_left);
            end
            if (i < 14) begin
                c_deal = vecs[i].deal;
                c_shuf = vecs[i].shuf;
                if (vecs[i].exp_valid) c_exp_q.push_back(vecs[i].exp_card);
            end else begin
                c_deal = 1'b0;
                c_shuf = 1'b0;
            end
            @(negedge clk);
        end

        // Reload, then drain the whole deck with deal_req held for 53 cycles.
        c_shuf = 1'b1;
        @(negedge clk);
        c_shuf = 1'b0;
        check("t2_busy_after_shuf", int'(c_busy), 1);
        @(negedge clk);
        check("t2_ready_after_load", int'(c_busy), 0);
        check("t2_left_full", int'(c_left), 52);
        c_dealt.delete();
        v0 = c_valid_cnt;
        for (int j = 0; j < 53; j++) begin
            c_deal = 1'b1;
            if (j < 52) c_exp_q.push_back(canon(j));
            @(negedge clk);
            if (j == 51) begin
                check("t2_empty_after_52", int'(c_empty), 1);
                check("t2_left_after_52", int'(c_left), 0);
            end
            if (j == 52) check("t2_no_53rd_strobe", int'(c_valid), 0);
        end
        c_deal = 1'b0;
        @(negedge clk);
        check("t2_strobes", c_valid_cnt - v0, 52);
        check("t2_sb_drained", c_exp_q.size(), 0);
        for (int v = 0; v < 11; v++) h[v] = 0;
        foreach (c_dealt[k]) if (c_dealt[k] >= 1 && c_dealt[k] <= 10) h[c_dealt[k]]++;
        for (int v = 1; v <= 9; v++) check($sformatf("t2_hist_%0d", v), h[v], 4);
        check("t2_hist_10", h[10], 16);

        // Shuffled 2-deck shoe against the reference model.
        run_shuffle(0);

        s_deal = 1'b1;
        @(negedge clk);
        s_deal = 1'b0;
        check("s_deal_when_empty", int'(s_valid), 0);
        check("s_left_stays_zero", int'(s_left), 0);

        s_free = 1'b1;
        s_shuf = 1'b1;
        @(negedge clk);
        s_shuf = 1'b0;
        check("t4_busy_after_shuf", int'(s_busy), 1);
        check("t4_empty_cleared", int'(s_empty), 0);
        wait_ready_s(cyc);
        check("t4_left_full", int'(s_left), 104);
        v0 = s_valid_cnt;
        for (int k = 0; k < 10; k++) begin
            s_deal = 1'b1;
            @(negedge clk);
        end
        s_deal = 1'b0;
        @(negedge clk);
        check("t4_ten_dealt", s_valid_cnt - v0, 10);
        check("t4_left_94", int'(s_left), 94);

        s_shuf = 1'b1;
        @(negedge clk);
        s_shuf = 1'b0;
        s_deal = 1'b1;
        check("t4_busy_mid_game", int'(s_busy), 1);
        check("t4_valid_on_shuf", int'(s_valid), 0);
        @(negedge clk);
        check("t4_left_after_load", int'(s_left), 104);
        strobes = 0;
        for (int k = 0; k < 4000 && s_busy; k++) begin
            @(negedge clk);
            if (s_valid) strobes++;
        end
        s_deal = 1'b0;
        check("t4_no_card_while_busy", strobes, 0);
        check("t4_ready_again", int'(s_busy), 0);

        // Shuffle and deal requested together: shuffle wins.
        s_deal = 1'b1;
        s_shuf = 1'b1;
        @(negedge clk);
        s_deal = 1'b0;
        s_shuf = 1'b0;
        check("t5_valid", int'(s_valid), 0);
        check("t5_busy", int'(s_busy), 1);
        repeat (3) @(negedge clk);
        check("t5_still_shuffling", int'(s_busy), 1);
        check("t5_left", int'(s_left), 104);

        // Asynchronous reset mid-shuffle, checked between clock edges.
        #2 s_rst_n = 1'b0;
        #1;
        check("t6_rst_card", int'(s_card), 0);
        check("t6_rst_valid", int'(s_valid), 0);
        check("t6_rst_busy", int'(s_busy), 1);
        check("t6_rst_empty", int'(s_empty), 0);
        check("t6_rst_left", int'(s_left), 0);
        repeat (2) @(negedge clk);
        run_shuffle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
